uart_tx_frame: RTL and testbench

// - Serial UART transmitter, 8N1 framing. It consumes the byte/start handshake issued by the

---
 rtl/uart_tx_frame.sv | 133 +++++++++++++
 tb/tb_uart_tx_frame.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// 8N1 UART transmitter: a baud counter, a frame FSM and an LSB-first shift register.
// Define UART_TX_PARITY_EN to insert a parity bit (sense chosen by ODD) between data and stop.
`timescale 1ns/1ps

module uart_tx_frame #(
    parameter int BAUD = 104,
    parameter int ODD  = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (BAUD > 2) ? $clog2(BAUD) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // Catch illegal parameterisations at elaboration rather than in silicon.
    if (BAUD < 2) begin : g_bad_baud
        $error("uart_tx_frame: BAUD must be >= 2");
    end
    if (ODD != 0 && ODD != 1) begin : g_bad_odd
        $error("uart_tx_frame: ODD must be 0 or 1");
    end

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          baud_end;

`ifdef UART_TX_PARITY_EN
    localparam logic ODD_BIT = 1'(ODD);
    logic par_bit;
`endif

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            ready    <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            // The baud counter only runs while a frame is on the line.
            if (state == S_IDLE || baud_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start && ready) begin
                        shreg   <= data;
`ifdef UART_TX_PARITY_EN
                        par_bit <= (^data) ^ ODD_BIT;
`endif
                        tx      <= 1'b0;
                        ready   <= 1'b0;
                        bit_cnt <= 3'd0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            tx      <= par_bit;
                            state   <= S_PARITY;
`else
                            tx      <= 1'b1;
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_end) begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // ready rises on the edge that ends the stop bit; tx stays high.
                    if (baud_end) begin
                        tx    <= 1'b1;
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at BAUD=4: frame table, held start, busy ignore, mid-frame reset.
`timescale 1ns/1ps

module tb_uart_tx_frame;

    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] data;
    logic       start;
    logic       ready;
    logic       tx;

    always #5 clk = ~clk;

    uart_tx_frame #(.BAUD(BAUD), .ODD(0)) dut (
        .clk(clk), .rstn(rstn), .data(data), .start(start), .ready(ready), .tx(tx)
    );

`ifdef UART_TX_PARITY_EN
    logic ready_odd;
    logic tx_odd;
    uart_tx_frame #(.BAUD(BAUD), .ODD(1)) dut_odd (
        .clk(clk), .rstn(rstn), .data(data), .start(start), .ready(ready_odd), .tx(tx_odd)
    );
`endif

    // frame: bit i is the i-th bit on the line (start, d0..d7, stop); par: even parity of data.
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t vecs[7];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] frame_of(input int i);
`ifdef UART_TX_PARITY_EN
        return {1'b1, vecs[i].par, vecs[i].frame[8:0]};
`else
        return {1'b0, vecs[i].frame};
`endif
    endfunction

    task automatic drive_accept(input logic [7:0] d);
        @(posedge clk);
        #1;
        data  = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called just after the accept edge; checks every cycle of every bit and ready's return.
    task automatic check_frame(input logic [10:0] exp);
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < BAUD; c++) begin
                @(negedge clk);
                chk("tx_bit", {31'd0, tx}, {31'd0, exp[i]});
                chk("ready_busy", {31'd0, ready}, 32'd0);
`ifdef UART_TX_PARITY_EN
                chk("tx_bit_odd", {31'd0, tx_odd}, {31'd0, exp[i] ^ (i == 9)});
                chk("ready_busy_odd", {31'd0, ready_odd}, 32'd0);
`endif
            end
        end
        @(negedge clk);
        chk("ready_return", {31'd0, ready}, 32'd1);
        chk("tx_after_stop", {31'd0, tx}, 32'd1);
`ifdef UART_TX_PARITY_EN
        chk("ready_return_odd", {31'd0, ready_odd}, 32'd1);
`endif
    endtask

    task automatic check_idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk("idle_tx", {31'd0, tx}, 32'd1);
            chk("idle_ready", {31'd0, ready}, 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{data: 8'h48, frame: 10'b1010010000, par: 1'b0};
        vecs[1] = '{data: 8'h6F, frame: 10'b1011011110, par: 1'b0};
        vecs[2] = '{data: 8'hA5, frame: 10'b1101001010, par: 1'b0};
        vecs[3] = '{data: 8'h00, frame: 10'b1000000000, par: 1'b0};
        vecs[4] = '{data: 8'hFF, frame: 10'b1111111110, par: 1'b0};
        vecs[5] = '{data: 8'h01, frame: 10'b1000000010, par: 1'b1};
        vecs[6] = '{data: 8'h80, frame: 10'b1100000000, par: 1'b1};

        // Reset held for 3 cycles, then 100 idle cycles.
        rstn  = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_tx", {31'd0, tx}, 32'd1);
            chk("reset_ready", {31'd0, ready}, 32'd1);
        end
        rstn = 1'b1;
        check_idle(100);

        // Table of single frames, start pulsed for one cycle.
        for (int i = 0; i < 7; i++) begin
            drive_accept(vecs[i].data);
            check_frame(frame_of(i));
        end

        // Held start: frames back to back, 41 cycles apart, ready high for one cycle.
        @(posedge clk);
        #1;
        data  = 8'h6F;
        start = 1'b1;
        @(posedge clk);
        #1;
        check_frame(frame_of(1));
        check_frame(frame_of(1));
        start = 1'b0;
        check_idle(5);

        // Busy ignore: new data and start while 0xA5 is on the line.
        drive_accept(8'hA5);
        fork
            check_frame(frame_of(2));
            begin
                repeat (8) @(posedge clk);
                #1;
                data  = 8'h00;
                start = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        check_idle(50);

        // Mid-frame reset during data bit 3 (0 for 0xA5), then a clean frame.
        drive_accept(8'hA5);
        repeat (17) @(posedge clk);
        #2;
        chk("pre_reset_tx", {31'd0, tx}, 32'd0);
        chk("pre_reset_ready", {31'd0, ready}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("async_reset_tx", {31'd0, tx}, 32'd1);
        chk("async_reset_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        check_idle(3);
        drive_accept(8'h48);
        check_frame(frame_of(0));
        check_idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
